npc_pc_unit: RTL and testbench
==============================

# npc_pc_unit

Fetch-stage program-counter unit for the five-stage MIPS pipeline. It holds the PC register, computes the next fetch address from the instruction in D (j/jal/jr/jalr/branches, with delay slot), and handles exception entry and `eret` return through an EPC register and exception-level bit. It also flags fetch addresses outside instruction memory. It sits between F and D; the M-stage exception logic drives it directly.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset and the base of instruction memory.
- `EXC_VECTOR`, 32'h0000_4180, exception handler entry address.
- `IM_WORDS`, 1024, instruction-memory depth in words; legal fetch range is [RESET_PC, RESET_PC+4*IM_WORDS).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall; holds the PC.
- `IR_D`  in  32  instruction in D; a bubble is 32'h0.
- `pc8_D`  in  32  PC of the D instruction + 8.
- `cmp_taken_D`  in  1  D-stage branch-condition result for the instruction in `IR_D`.
- `rs_val_D`  in  32  forwarded GPR[rs] for jr/jalr.
- `exc_req_M`  in  1  exception/interrupt committing in M.
- `exc_epc_M`  in  32  return address to save on exception.
- `eret_M`  in  1  eret committing in M.
- `pc_F`  out  32  current fetch address (registered).
- `npc`  out  32  address to be loaded at the next edge (combinational).
- `redirect_D`  out  1  D instruction redirects the PC this cycle.
- `fetch_err`  out  1  `pc_F` is misaligned or out of range.
- `epc`  out  32  saved return address.
- `exl`  out  1  exception level; 1 while in the handler.

## Operation
- Decode of `IR_D`, using opcode [31:26], rt [20:16] and funct [5:0]:
  - j 000010, jal 000011: target {pc8_D[31:28], IR_D[25:0], 2'b00}.
  - beq 000100, bne 000101, blez 000110, bgtz 000111.
  - REGIMM 000001 with rt 00000 (bltz) or rt 00001 (bgez).
  - SPECIAL 000000 with funct 001000 (jr) or 001001 (jalr): target `rs_val_D`.
- Branch target is pc8_D − 4 + (sign_extend(IR_D[15:0]) << 2), mod 2^32. A branch redirects only when `cmp_taken_D`=1.
- Jumps always redirect. Any other encoding, including 0, does not redirect.
- `redirect_D` is 1 when D holds a jump, or a taken branch, regardless of stall. Delay slot: the instruction already in F is not squashed.
- `npc` selection, highest priority first:
  1. `exc_req_M`: EXC_VECTOR.
  2. `eret_M`: `epc`.
  3. `stall`: `pc_F`.
  4. `redirect_D`: the decoded target.
  5. Otherwise: `pc_F` + 4.
- At each edge, `pc_F` <= `npc`.
- Exception-level state machine, two states:
  - NORMAL (`exl`=0): on `exc_req_M`, `epc` <= `exc_epc_M` and the state goes to HANDLER.
  - HANDLER (`exl`=1): on `exc_req_M`, the PC still goes to EXC_VECTOR but `epc` and `exl` are unchanged. On `eret_M` (without `exc_req_M`), go to NORMAL.
  - `eret_M` in NORMAL still loads `pc_F` <= `epc`; `exl` stays 0.
- `exc_req_M` and `eret_M` in the same cycle: the exception wins, and the eret is discarded.
- `fetch_err` = (`pc_F`[1:0] != 0) | (`pc_F` < RESET_PC) | (`pc_F` >= RESET_PC + 4*IM_WORDS), computed without overflow using 33-bit compares. This block only flags the error; raising the exception is the M-stage's responsibility. The PC keeps advancing.
- `rs_val_D` is used as-is. A misaligned jr target shows up as `fetch_err` on the following cycle.

## Timing
- Reset values: `pc_F`=RESET_PC, `epc`=0, `exl`=0. `reset` overrides every other input on that edge.
- `npc` and `redirect_D` are combinational from the current inputs and state. All other outputs are registered.
- Redirect latency: a jump or taken branch in D in cycle k (no stall) gives `pc_F` = target in cycle k+1.
- Exception latency: `exc_req_M` in cycle k gives `pc_F`=EXC_VECTOR and `exl`=1 in cycle k+1. Eret has the same one-cycle latency.
- Stall together with a D redirect: the PC holds. The redirect takes effect in the first non-stalled cycle, because D (and so `IR_D`) is held upstream.
- Exception or eret overrides a stall in the same cycle.
- Reset asserted mid-handler returns to NORMAL with `pc_F`=RESET_PC on the next edge.

## Test plan
- Reset, then 3 free cycles with `IR_D`=0 -> `pc_F` = 0x3000, 0x3004, 0x3008, 0x300C; `fetch_err`=0; `exl`=0.
- `IR_D`=0x1000_FFFF (beq, offset −1), `pc8_D`=0x3010, `cmp_taken_D`=1 -> `npc`=0x3008 and `pc_F`=0x3008 next cycle. Same with `cmp_taken_D`=0 -> `pc_F` = old + 4.
- `IR_D`=0x0C00_0C10 (jal), `pc8_D`=0x3008 -> `pc_F`=0x0000_3040. Then jr with `rs_val_D`=0x3012 -> `pc_F`=0x3012 and `fetch_err`=1.
- `stall`=1 for 2 cycles with a j in D -> `pc_F` held. When the stall drops, `pc_F` = the jump target one cycle later.
- `exc_req_M` with `exc_epc_M`=0x3024 -> `pc_F`=0x4180, `epc`=0x3024, `exl`=1. A second `exc_req_M` with `exc_epc_M`=0x4188 -> `epc` remains 0x3024. Then `eret_M` -> `pc_F`=0x3024, `exl`=0.
- `exc_req_M` and `eret_M` asserted together in NORMAL -> `pc_F`=0x4180 and `exl`=1. Then `reset` during the handler -> `pc_F`=0x3000, `exl`=0, `epc`=0.

Source files
------------

// File: rtl/npc_pc_unit_if.sv
// rtl/npc_pc_unit_if.sv - D/M-stage control and fetch-address bundle for npc_pc_unit
interface npc_pc_unit_if;
   logic        stall;
   logic [31:0] IR_D;
   logic [31:0] pc8_D;
   logic        cmp_taken_D;
   logic [31:0] rs_val_D;
   logic        exc_req_M;
   logic [31:0] exc_epc_M;
   logic        eret_M;
   logic [31:0] pc_F;
   logic [31:0] npc;
   logic        redirect_D;
   logic        fetch_err;
   logic [31:0] epc;
   logic        exl;

   modport master (
      output stall, IR_D, pc8_D, cmp_taken_D, rs_val_D, exc_req_M, exc_epc_M, eret_M,
      input  pc_F, npc, redirect_D, fetch_err, epc, exl
   );

   modport slave (
      input  stall, IR_D, pc8_D, cmp_taken_D, rs_val_D, exc_req_M, exc_epc_M, eret_M,
      output pc_F, npc, redirect_D, fetch_err, epc, exl
   );
endinterface

// File: rtl/npc_pc_unit.sv
// rtl/npc_pc_unit.sv - fetch PC register, next-PC select, EPC/EXL exception state
module npc_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter int unsigned IM_WORDS   = 1024
) (
   input  logic          clk,
   input  logic          reset,
   npc_pc_unit_if.slave  bus
);
   typedef enum logic {ST_NORMAL = 1'b0, ST_HANDLER = 1'b1} exl_state_e;

   localparam logic [32:0] IM_LO = {1'b0, RESET_PC};
   localparam logic [32:0] IM_HI = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   exl_state_e  state_q, state_d;
   logic        fetch_err_q, fetch_err_d;

   logic [5:0]  opcode, funct;
   logic [4:0]  rt;
   logic        is_jump_imm, is_jump_reg, is_branch;
   logic [31:0] br_target, target;
   logic        redirect;

   assign opcode = bus.IR_D[31:26];
   assign rt     = bus.IR_D[20:16];
   assign funct  = bus.IR_D[5:0];

   always_comb begin
      is_jump_imm = (opcode == 6'b000010) || (opcode == 6'b000011);
      is_jump_reg = (opcode == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001));
      is_branch   = (opcode == 6'b000100) || (opcode == 6'b000101) ||
                    (opcode == 6'b000110) || (opcode == 6'b000111) ||
                    ((opcode == 6'b000001) && ((rt == 5'b00000) || (rt == 5'b00001)));
      // pc8_D - 4 is the branch's own PC + 4, the base of the relative offset
      br_target   = bus.pc8_D - 32'd4 + {{14{bus.IR_D[15]}}, bus.IR_D[15:0], 2'b00};
      if (is_jump_imm)
         target = {bus.pc8_D[31:28], bus.IR_D[25:0], 2'b00};
      else if (is_jump_reg)
         target = bus.rs_val_D;
      else
         target = br_target;
      redirect = is_jump_imm || is_jump_reg || (is_branch && bus.cmp_taken_D);
   end

   always_comb begin
      pc_d    = pc_q + 32'd4;
      epc_d   = epc_q;
      state_d = state_q;
      if (bus.exc_req_M) begin
         pc_d = EXC_VECTOR;
         if (state_q == ST_NORMAL) begin
            epc_d   = bus.exc_epc_M;
            state_d = ST_HANDLER;
         end
      end else if (bus.eret_M) begin
         pc_d    = epc_q;
         state_d = ST_NORMAL;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (redirect) begin
         pc_d = target;
      end
      // Flag is computed on the incoming PC so it lines up with pc_F
      fetch_err_d = (pc_d[1:0] != 2'b00) ||
                    ({1'b0, pc_d} < IM_LO) ||
                    ({1'b0, pc_d} >= IM_HI);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         epc_q       <= 32'd0;
         state_q     <= ST_NORMAL;
         fetch_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         state_q     <= state_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign bus.pc_F       = pc_q;
   assign bus.npc        = pc_d;
   assign bus.redirect_D = redirect;
   assign bus.fetch_err  = fetch_err_q;
   assign bus.epc        = epc_q;
   assign bus.exl        = (state_q == ST_HANDLER);
endmodule

// File: tb/tb_npc_pc_unit.sv
// tb/tb_npc_pc_unit.sv - directed bench for npc_pc_unit
module tb_npc_pc_unit;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   npc_pc_unit_if bus ();

   npc_pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset           = 1'b1;
      bus.stall       = 1'b0;
      bus.IR_D        = 32'h0;
      bus.pc8_D       = 32'h0;
      bus.cmp_taken_D = 1'b0;
      bus.rs_val_D    = 32'h0;
      bus.exc_req_M   = 1'b0;
      bus.exc_epc_M   = 32'h0;
      bus.eret_M      = 1'b0;
      step();
      step();
      reset = 1'b0;

      chk("reset_pc", bus.pc_F, 32'h3000);
      chk("reset_epc", bus.epc, 32'h0);
      chk("reset_exl", {31'd0, bus.exl}, 32'd0);
      chk("reset_ferr", {31'd0, bus.fetch_err}, 32'd0);
      chk("bubble_npc", bus.npc, 32'h3004);
      step();
      chk("free_pc1", bus.pc_F, 32'h3004);
      step();
      chk("free_pc2", bus.pc_F, 32'h3008);
      step();
      chk("free_pc3", bus.pc_F, 32'h300C);
      chk("free_ferr", {31'd0, bus.fetch_err}, 32'd0);

      bus.IR_D = 32'h2400_0005;
      #1;
      chk("addiu_noredir", {31'd0, bus.redirect_D}, 32'd0);

      // beq offset -1, taken
      bus.IR_D = 32'h1000_FFFF; bus.pc8_D = 32'h3010; bus.cmp_taken_D = 1'b1;
      #1;
      chk("beq_npc", bus.npc, 32'h3008);
      chk("beq_redir", {31'd0, bus.redirect_D}, 32'd1);
      step();
      chk("beq_pc", bus.pc_F, 32'h3008);
      bus.cmp_taken_D = 1'b0;
      #1;
      chk("beq_nt_redir", {31'd0, bus.redirect_D}, 32'd0);
      step();
      chk("beq_nt_pc", bus.pc_F, 32'h300C);

      // bgez (REGIMM rt=1) offset +4, taken from pc8 0x3014
      bus.IR_D = 32'h0401_0004; bus.pc8_D = 32'h3014; bus.cmp_taken_D = 1'b1;
      step();
      chk("bgez_pc", bus.pc_F, 32'h3020);
      bus.cmp_taken_D = 1'b0;

      bus.IR_D = 32'h0C00_0C10; bus.pc8_D = 32'h3008;
      step();
      chk("jal_pc", bus.pc_F, 32'h3040);
      bus.IR_D = 32'h03E0_0008; bus.rs_val_D = 32'h3012;
      step();
      chk("jr_pc", bus.pc_F, 32'h3012);
      chk("jr_ferr", {31'd0, bus.fetch_err}, 32'd1);

      // j 0x3080 under a two-cycle stall
      bus.IR_D = 32'h0800_0C20; bus.pc8_D = 32'h301A; bus.stall = 1'b1;
      #1;
      chk("stall_redir", {31'd0, bus.redirect_D}, 32'd1);
      step();
      chk("stall_pc1", bus.pc_F, 32'h3012);
      step();
      chk("stall_pc2", bus.pc_F, 32'h3012);
      bus.stall = 1'b0;
      step();
      chk("j_after_stall", bus.pc_F, 32'h3080);
      chk("j_ferr", {31'd0, bus.fetch_err}, 32'd0);
      bus.IR_D = 32'h0;

      bus.exc_req_M = 1'b1; bus.exc_epc_M = 32'h3024;
      step();
      chk("exc_pc", bus.pc_F, 32'h4180);
      chk("exc_epc", bus.epc, 32'h3024);
      chk("exc_exl", {31'd0, bus.exl}, 32'd1);
      bus.exc_epc_M = 32'h4188;
      step();
      chk("exc2_pc", bus.pc_F, 32'h4180);
      chk("exc2_epc", bus.epc, 32'h3024);
      chk("exc2_exl", {31'd0, bus.exl}, 32'd1);
      bus.exc_req_M = 1'b0; bus.eret_M = 1'b1; bus.stall = 1'b1;
      #1;
      chk("eret_npc", bus.npc, 32'h3024);
      step();
      chk("eret_pc", bus.pc_F, 32'h3024);
      chk("eret_exl", {31'd0, bus.exl}, 32'd0);
      bus.stall = 1'b0;
      step();
      chk("eret_normal_pc", bus.pc_F, 32'h3024);
      chk("eret_normal_exl", {31'd0, bus.exl}, 32'd0);

      // exception and eret together: exception wins
      bus.exc_req_M = 1'b1; bus.exc_epc_M = 32'h3030;
      step();
      chk("both_pc", bus.pc_F, 32'h4180);
      chk("both_exl", {31'd0, bus.exl}, 32'd1);
      chk("both_epc", bus.epc, 32'h3030);
      bus.exc_req_M = 1'b0; bus.eret_M = 1'b0;
      step();
      chk("handler_pc", bus.pc_F, 32'h4184);
      chk("handler_ferr", {31'd0, bus.fetch_err}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_mid_pc", bus.pc_F, 32'h3000);
      chk("rst_mid_exl", {31'd0, bus.exl}, 32'd0);
      chk("rst_mid_epc", bus.epc, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
